// File: rtl/fft_pingpong_ram.sv
// fft_pingpong_ram
//   Double-buffered sample RAM feeding the FFT core. Samples are written in
//   natural order into one bank while the previously completed frame is read
//   from the other bank, in natural or bit-reversed order. Bank swapping and
//   output framing are internal, so the core sees a continuous framed stream.
//
// Ports
//   CLK    clock, rising edge
//   RST    synchronous active-high reset, overrides ED
//   ED     clock enable; ED=0 freezes all state, memory and outputs
//   START  DI is sample 0 of a frame (also resyncs a frame in progress)
//   DI     input sample [NB-1:0]
//   DO     registered output sample [NB-1:0]
//   DV     DO holds a valid sample
//   RDY    DO holds sample 0 of an output frame
//
// Handshake: there is no back-pressure. A sample is accepted on every ED edge
// once framing has started, and an output sample is presented on every ED
// edge where DV=1; consumers qualify DV/RDY with ED.
module fft_pingpong_ram #(
  parameter int NB     = 12,
  parameter int AW     = 8,
  parameter int BITREV = 1
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          ED,
  input  logic          START,
  input  logic [NB-1:0] DI,
  output logic [NB-1:0] DO,
  output logic          DV,
  output logic          RDY
);

  localparam int N = 1 << AW;

  localparam logic [0:0] W_IDLE = 1'b0;
  localparam logic [0:0] W_FILL = 1'b1;
  localparam logic [0:0] R_IDLE = 1'b0;
  localparam logic [0:0] R_RUN  = 1'b1;

  localparam logic [AW-1:0] LAST = '1;
  localparam logic [AW-1:0] ONE  = AW'(1);

  // Bank is the MSB of the physical address.
  logic [NB-1:0] mem [0:2*N-1];

  logic [0:0]    w_state;
  logic [AW-1:0] wcnt;
  logic          wbank;

  logic [0:0]    r_state;
  logic [AW-1:0] rcnt;
  logic          rbank;

  // First read stage: latched address and its framing flags.
  logic [AW-1:0] raddr;
  logic          rbank_d;
  logic          issue_v;
  logic          issue_first;

  logic          we;
  logic [AW-1:0] waddr;
  logic          frame_done;
  logic [AW-1:0] rd_addr;

  function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] a);
    logic [AW-1:0] r;
    for (int i = 0; i < AW; i++) r[i] = a[AW-1-i];
    return r;
  endfunction

  always_comb begin
    we         = ED && ((w_state == W_FILL) || START);
    waddr      = START ? '0 : wcnt;
    // A START on the edge that would write word N-1 is a resync, not a completion.
    frame_done = ED && (w_state == W_FILL) && !START && (wcnt == LAST);
    rd_addr    = (BITREV != 0) ? bitrev(rcnt) : rcnt;
  end

  // Sample memory, not reset.
  always_ff @(posedge CLK) begin
    if (we && !RST) mem[{wbank, waddr}] <= DI;
  end

  // Write FSM
  always_ff @(posedge CLK) begin
    if (RST) begin
      w_state <= W_IDLE;
      wcnt    <= '0;
      wbank   <= 1'b0;
    end else if (ED) begin
      if (START) begin
        // Restart the frame in the same bank; a partial frame is discarded.
        wcnt    <= ONE;
        w_state <= W_FILL;
      end else if (w_state == W_FILL) begin
        wcnt <= wcnt + ONE;
        if (wcnt == LAST) wbank <= ~wbank;
      end
    end
  end

  // Read FSM and address stage
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= R_IDLE;
      rcnt        <= '0;
      rbank       <= 1'b0;
      raddr       <= '0;
      rbank_d     <= 1'b0;
      issue_v     <= 1'b0;
      issue_first <= 1'b0;
    end else if (ED) begin
      issue_v     <= (r_state == R_RUN);
      issue_first <= (r_state == R_RUN) && (rcnt == '0);
      if (r_state == R_RUN) begin
        raddr   <= rd_addr;
        rbank_d <= rbank;
        rcnt    <= rcnt + ONE;
        if (rcnt == LAST) r_state <= R_IDLE;
      end
      // A new completed frame overrides the idle return so back-to-back
      // frames stream out with no gap.
      if (frame_done) begin
        rbank   <= wbank;
        rcnt    <= '0;
        r_state <= R_RUN;
      end
    end
  end

  // Data stage
  always_ff @(posedge CLK) begin
    if (RST) begin
      DO  <= '0;
      DV  <= 1'b0;
      RDY <= 1'b0;
    end else if (ED) begin
      DV  <= issue_v;
      RDY <= issue_first;
      if (issue_v) DO <= mem[{rbank_d, raddr}];
    end
  end

endmodule

// File: tb/tb_fft_pingpong_ram.sv
// tb_fft_pingpong_ram
//   Drives two instances (natural and bit-reversed read order) with the same
//   input stream. A frame model pushes every expected output sample, with its
//   RDY flag and the ED-edge index at which it must appear, into one queue
//   per instance; the monitor pops and compares when DV is seen.
module tb_fft_pingpong_ram;

  localparam int NB = 12;
  localparam int AW = 8;
  localparam int N  = 1 << AW;
  localparam int EW = 32 + 1 + NB;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          ED = 1'b0;
  logic          START = 1'b0;
  logic [NB-1:0] DI = '0;
  logic [NB-1:0] do0, do1;
  logic          dv0, dv1, rdy0, rdy1;

  fft_pingpong_ram #(.NB(NB), .AW(AW), .BITREV(0)) dut0 (
    .CLK(CLK), .RST(RST), .ED(ED), .START(START), .DI(DI),
    .DO(do0), .DV(dv0), .RDY(rdy0)
  );

  fft_pingpong_ram #(.NB(NB), .AW(AW), .BITREV(1)) dut1 (
    .CLK(CLK), .RST(RST), .ED(ED), .START(START), .DI(DI),
    .DO(do1), .DV(dv1), .RDY(rdy1)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  // scoreboard state
  int n_checks = 0;
  int n_errors = 0;
  int ed_cnt   = 0;

  logic [EW-1:0] exp0_q[$];
  logic [EW-1:0] exp1_q[$];

  logic [NB-1:0] frame [N];
  int            fill   = 0;
  bit            active = 0;

  logic [NB-1:0] last_do  [2];
  logic          last_dv  [2];
  logic          last_rdy [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int rev(input int k);
    int r = 0;
    for (int i = 0; i < AW; i++) r = (r << 1) | ((k >> i) & 1);
    return r;
  endfunction

  function automatic int qsize(input int id);
    return (id == 0) ? exp0_q.size() : exp1_q.size();
  endfunction

  function automatic logic [EW-1:0] qfront(input int id);
    return (id == 0) ? exp0_q[0] : exp1_q[0];
  endfunction

  task automatic qpop(input int id);
    if (id == 0) void'(exp0_q.pop_front());
    else         void'(exp1_q.pop_front());
  endtask

  task automatic push_frame();
    logic [31:0] due;
    for (int k = 0; k < N; k++) begin
      due = 32'(ed_cnt + 2 + k);
      exp0_q.push_back({due, (k == 0), frame[k]});
      exp1_q.push_back({due, (k == 0), frame[rev(k)]});
    end
  endtask

  // Input-side frame model, applied after each edge.
  task automatic model(input logic ed, input logic start, input logic rst_i, input logic [NB-1:0] di);
    if (rst_i) begin
      active = 0;
      fill   = 0;
      exp0_q.delete();
      exp1_q.delete();
    end else if (ed) begin
      ed_cnt++;
      if (start) begin
        frame[0] = di;
        fill     = 1;
        active   = 1;
      end else if (active) begin
        frame[fill] = di;
        fill++;
        if (fill == N) begin
          push_frame();
          fill = 0;
        end
      end
    end
  endtask

  task automatic mon(input int id, input logic ed, input logic rst_i,
                     input logic [NB-1:0] d, input logic v, input logic r);
    logic [EW-1:0] e;
    string         sfx;
    sfx = $sformatf("_dut%0d", id);
    if (rst_i) begin
      check({"rst_do", sfx}, 32'(d), 0);
      check({"rst_dv", sfx}, 32'(v), 0);
      check({"rst_rdy", sfx}, 32'(r), 0);
      last_do[id] = '0; last_dv[id] = 1'b0; last_rdy[id] = 1'b0;
    end else if (ed) begin
      if (v) begin
        if (qsize(id) == 0) begin
          check({"dv_spurious", sfx}, 32'(v), 0);
          last_dv[id] = 1'b0; last_rdy[id] = 1'b0;
        end else begin
          e = qfront(id);
          qpop(id);
          check({"data", sfx}, 32'(d), 32'(e[NB-1:0]));
          check({"rdy", sfx}, 32'(r), 32'(e[NB]));
          check({"due", sfx}, 32'(ed_cnt), e[EW-1:NB+1]);
          last_do[id] = e[NB-1:0]; last_dv[id] = 1'b1; last_rdy[id] = e[NB];
        end
      end else begin
        if (qsize(id) > 0) begin
          e = qfront(id);
          if (e[EW-1:NB+1] <= 32'(ed_cnt)) begin
            check({"dv_missing", sfx}, 32'(v), 1);
            qpop(id);
          end
        end
        check({"rdy_no_dv", sfx}, 32'(r), 0);
        last_dv[id] = 1'b0; last_rdy[id] = 1'b0;
      end
    end else begin
      check({"hold_dv", sfx}, 32'(v), 32'(last_dv[id]));
      check({"hold_rdy", sfx}, 32'(r), 32'(last_rdy[id]));
      if (last_dv[id]) check({"hold_do", sfx}, 32'(d), 32'(last_do[id]));
    end
  endtask

  // driver tasks
  task automatic step(input logic ed, input logic start, input logic rst_i, input logic [NB-1:0] di);
    ED = ed; START = start; RST = rst_i; DI = di;
    @(posedge CLK);
    model(ed, start, rst_i, di);
    #1;
    mon(0, ed, rst_i, do0, dv0, rdy0);
    mon(1, ed, rst_i, do1, dv1, rdy1);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) step(1'($urandom_range(0, 1)), 1'b0, 1'b1, NB'($urandom_range(0, 4095)));
  endtask

  // n ED=1 writes; toggle inserts an ED=0 cycle with junk DI/START before each.
  task automatic send(input int n, input bit first_start, input int base, input bit rnd, input bit toggle);
    for (int i = 0; i < n; i++) begin
      if (toggle) step(1'b0, 1'($urandom_range(0, 1)), 1'b0, NB'($urandom_range(0, 4095)));
      step(1'b1, first_start && (i == 0), 1'b0, rnd ? NB'($urandom_range(0, 4095)) : NB'(base + i));
    end
  endtask

  // Lets pending output stream out; the mid-point resync keeps the filler
  // writes from ever completing a frame.
  task automatic drain(input int n, input bit toggle);
    for (int i = 0; i < n; i++) begin
      if (toggle) step(1'b0, 1'($urandom_range(0, 1)), 1'b0, NB'($urandom_range(0, 4095)));
      step(1'b1, (i == n / 2), 1'b0, NB'($urandom_range(0, 4095)));
    end
  endtask

  initial begin
    // reset overrides ED; outputs must be zero
    do_reset(3);

    // natural ramp followed back-to-back by 1000+k without START
    send(N, 1, 0, 0, 0);
    send(N, 0, 1000, 0, 0);
    drain(N + 4, 0);

    // ED toggling 1,0,1,0 with junk on DI/START during ED=0
    do_reset(1);
    send(N, 1, 0, 0, 1);
    drain(N + 4, 1);

    // resync after 100 words while the previous frame is being read
    do_reset(1);
    send(N, 1, 0, 1, 0);
    send(100, 0, 0, 1, 0);
    send(N, 1, 0, 1, 0);
    drain(N + 4, 0);

    // reset during output, unframed input ignored, then a new framed frame
    send(N, 1, 0, 1, 0);
    send(50, 0, 0, 1, 0);
    do_reset(1);
    send(300, 0, 0, 1, 0);
    send(N, 1, 0, 1, 0);
    drain(N + 4, 0);

    check("queue_empty_dut0", 32'(exp0_q.size()), 0);
    check("queue_empty_dut1", 32'(exp1_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/fft_pingpong_ram.md
# fft_pingpong_ram

Parametrised double-buffered (ping-pong) sample RAM for the FFT datapath, successor to the single-port 256-word buffer. Incoming samples are written in natural order into one bank while the previously completed frame is read out of the other bank, in natural or bit-reversed order. Frame sequencing, bank swapping and output framing are handled internally, so the FFT core receives a continuous, framed sample stream. All activity is qualified by the codebase's ED clock-enable.

## Interface
Parameters:
- NB, 12, sample data width in bits.
- AW, 8, address width; each bank holds N = 2^AW words (2*N words total).
- BITREV, 1, read order: 1 reads addresses in AW-bit bit-reversed order, 0 reads in natural order.

Ports:
- CLK  input  1  clock; all logic on the rising edge.
- RST  input  1  reset, synchronous, active-high; overrides ED.
- ED  input  1  enable; when 0 all state, memory and outputs are frozen, and DI/START are ignored.
- START  input  1  marks DI as sample 0 of a frame; sampled only when ED=1.
- DI  input  NB  input sample.
- DO  output  NB  output sample (registered).
- DV  output  1  DO holds a valid output sample.
- RDY  output  1  DO holds sample 0 of an output frame.

## Operation
- Write FSM, states W_IDLE and W_FILL; counter wcnt[AW-1:0]; bank select wbank.
  - W_IDLE, ED&START: write DI to bank[wbank][0], set wcnt=1, go to W_FILL. DI without START is ignored.
  - W_FILL, ED: write DI to bank[wbank][wcnt] and increment wcnt.
    - If START=1 (resync), write DI to address 0 and set wcnt=1. The partial frame is discarded and the bank is not swapped.
    - When word N-1 is written (frame complete), wcnt wraps to 0, wbank toggles and the FSM stays in W_FILL. Writing is continuous; the next sample goes to word 0 of the other bank without needing START.
- Read FSM, states R_IDLE and R_RUN; counter rcnt[AW-1:0]; bank select rbank.
  - A frame-complete event sets rbank to the just-filled bank, clears rcnt and enters R_RUN.
  - R_RUN, ED: latch the read address (bitrev(rcnt) if BITREV=1, else rcnt) and increment rcnt. After issuing address N-1, return to R_IDLE unless a new frame-complete event occurs on the same edge; in that case restart at rcnt=0 with the new bank, with no gap.
- Read pipeline, two stages gated by ED: address register, then DO <= bank[rbank_d][raddr]. DV and RDY are pipelined alongside DO. RDY=1 only for the sample issued at rcnt=0.
- Bank safety:
  - A write never targets the bank being read, because reading N words takes exactly N ED cycles.
  - A resync only delays the next frame-complete event, so a read always finishes before the next swap.
- Bit reverse: for AW=8, rcnt 1 reads address 128, rcnt 2 reads 64, rcnt 3 reads 192.
- Memory contents are not reset.

## Timing
- Reset values: DO=0, DV=0, RDY=0. Internally: W_IDLE, R_IDLE, wcnt=0, rcnt=0, wbank=0, pipeline valids=0.
- RST takes effect at the next edge regardless of ED and aborts any frame in progress. A frame is not output until a full new frame has been written after START.
- Latency: if edge E (ED=1) writes word N-1, then:
  - the next ED edge latches read address 0;
  - the ED edge after that puts sample 0 on DO with DV=1 and RDY=1.
  - In total, the first output appears 2 ED-qualified edges after the last write.
- Outputs change only on ED edges and hold their values while ED=0. Downstream logic qualifies DV/RDY with ED.
- RDY is high for exactly one ED cycle per frame. With continuous input, DV stays 1 with no gaps, and RDY repeats every N ED cycles.
- START on the same edge that would write word N-1 counts as a resync: the write goes to address 0 and no frame completes.

## Test plan
- AW=8, BITREV=0, ED=1: START, DI=0..255, then hold DI → DO=0..255 starting 2 cycles after the last write; RDY high only with DO=0; DV high for 256 cycles.
- BITREV=1, same stimulus → DO sequence 0,128,64,192,32,160,… covering all 256 values exactly once.
- Two back-to-back frames, second frame DI=1000+k → DV has no gap; RDY pulses 256 cycles apart; second frame output is 1000+bitrev(k).
- ED toggling 1,0,1,0 throughout → the sequence over ED=1 cycles matches the ED=1 test; DO/DV/RDY hold steady during ED=0.
- START reasserted after 100 words of a frame → no output from the partial frame; output begins 2 ED cycles after the 256th word following the resync; an in-progress read completes unchanged.
- RST asserted during output → DO=0, DV=0, RDY=0 at the next edge; DI without START is then ignored; output resumes only after a full START-framed frame.
